// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          BCD_DIGITS = 8;
  localparam int          NIB_W      = 4;
  localparam int          BCD_W      = BCD_DIGITS * NIB_W;
  localparam logic [3:0]  ADJ_THRESH = 4'd5;
  localparam logic [3:0]  ADJ_ADD    = 4'd3;
  localparam logic [3:0]  OVF_NIBBLE = 4'hE;
  localparam int unsigned MAX_DEC    = 99_999_999;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a conversion requester and bin2bcd_seq.
interface bin2bcd_seq_if #(
  parameter int IN_W = 32
);
  logic            i_start;
  logic [IN_W-1:0] i_bin;
  logic            o_busy;
  logic            o_done;
  logic            o_ovf;
  logic [63:0]     o_data;

  // Requester side: issues start/value, observes status and result.
  modport master (
    output i_start, i_bin,
    input  o_busy, o_done, o_ovf, o_data
  );

  // Converter side.
  modport slave (
    input  i_start, i_bin,
    output o_busy, o_done, o_ovf, o_data
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a nibble of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [NIB_W-1:0] nib_in,
  output logic [NIB_W-1:0] nib_out
);

  assign nib_out = (nib_in >= ADJ_THRESH) ? nib_in + ADJ_ADD : nib_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary to 8-digit packed BCD converter, one input bit per clock.
// Upper 32 bits of o_data stay zero so the display driver sees plain digits.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int          IN_W    = 32,
  parameter int unsigned MAX_DEC = bcd_pkg::MAX_DEC
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bus
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
  localparam logic [BCD_W-1:0] OVF_WORD = {BCD_DIGITS{OVF_NIBBLE}};

  state_t           state, state_nxt;
  logic [IN_W-1:0]  bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;
  logic [BCD_W-1:0] data_q;
  logic             ovf_q;
  logic             done_q;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_in  (bcd_sr [g*NIB_W +: NIB_W]),
      .nib_out (bcd_adj[g*NIB_W +: NIB_W])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking (<=) so every register
    // sees the pre-edge values of the others, regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, IN_W shift steps, one DONE cycle.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.i_start)     state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:                         state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, shift-and-add-3 in SHIFT, publish when leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Result strobe lines up with the cycle where o_data/o_ovf are new.
      done_q <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            bin_sr   <= bus.i_bin;
            bcd_sr   <= '0;
            cnt      <= '0;
            ovf_pend <= (64'(bus.i_bin) > 64'(MAX_DEC));
          end
        end
        SHIFT: begin
          // The corrected top nibble's MSB falls off; only matters on overflow.
          bcd_sr <= BCD_W'({bcd_adj, bin_sr[IN_W-1]});
          bin_sr <= bin_sr << 1;
          cnt    <= cnt + 1'b1;
        end
        DONE: begin
          data_q <= ovf_pend ? OVF_WORD : bcd_sr;
          ovf_q  <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy = (state != IDLE);
  assign bus.o_done = done_q;
  assign bus.o_ovf  = ovf_q;
  assign bus.o_data = {32'd0, data_q};

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed boundaries plus random values
// compared against a decimal reference computed with plain arithmetic.
module tb_bin2bcd_seq;

  localparam logic [31:0] MAX_DEC = 32'd99_999_999;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  bin2bcd_seq_if bus ();

  bin2bcd_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: decimal digits by repeated division, or the overflow pattern.
  function automatic logic [63:0] model(input logic [31:0] v);
    logic [63:0] r;
    logic [31:0] x;
    r = '0;
    if (v > MAX_DEC) return {32'd0, 32'hEEEE_EEEE};
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accepting edge; returns edges until o_done is seen
  // and how many sampled cycles had o_busy high before that.
  task automatic wait_done(input bit toggle, output int lat, output int bcnt);
    lat  = 0;
    bcnt = int'(bus.o_busy);
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (toggle) bus.i_bin = $urandom;
      if (bus.o_done === 1'b1) break;
      bcnt += int'(bus.o_busy);
    end
  endtask

  // Full single conversion from an idle point, ending one cycle after o_done.
  task automatic convert(input logic [31:0] v, input string tag);
    int lat, bcnt;
    bus.i_start = 1'b1;
    bus.i_bin   = v;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    wait_done(1'b1, lat, bcnt);
    check({tag, "_lat"},  64'(lat),  64'd33);
    check({tag, "_busy"}, 64'(bcnt), 64'd33);
    check({tag, "_data"}, bus.o_data, model(v));
    check({tag, "_ovf"},  64'(bus.o_ovf), 64'(v > MAX_DEC));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(bus.o_done), 64'd0);
    check({tag, "_hold"},  bus.o_data, model(v));
  endtask

  initial begin
    int          lat, bcnt, dcnt;
    logic [31:0] vals [4];

    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", bus.o_data, 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_ovf",  64'(bus.o_ovf),  64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    convert(32'd0,           "zero");
    convert(32'd12_345_678,  "c12345678");
    convert(32'd99_999_999,  "max_dec");
    convert(32'd100_000_000, "max_dec_p1");
    convert(32'hFFFF_FFFF,   "all_ones");

    // Second start while busy must be ignored.
    bus.i_start = 1'b1;
    bus.i_bin   = 32'd1234;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_bin   = $urandom;
    repeat (4) @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_bin   = 32'd5678;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    wait_done(1'b1, lat, bcnt);
    check("ign_lat",  64'(lat), 64'd28);
    check("ign_data", bus.o_data, 64'h0000_0000_0000_1234);
    convert(32'd5678, "after_ign");

    // Random values, last one forced into overflow range.
    for (int i = 0; i < 4; i++) begin
      convert($urandom_range(0, 99_999_999), "rand_ok");
    end
    convert(32'hF000_0000 | $urandom, "rand_ovf");

    // Reset in the middle of a conversion.
    bus.i_start = 1'b1;
    bus.i_bin   = 32'd42;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_data", bus.o_data, 64'd0);
    check("abort_busy", 64'(bus.o_busy), 64'd0);
    check("abort_ovf",  64'(bus.o_ovf),  64'd0);
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      dcnt += int'(bus.o_done);
    end
    check("abort_nodone", 64'(dcnt), 64'd0);
    convert(32'd42, "after_abort");

    // Start held high: accept every 34 cycles.
    vals[0] = $urandom_range(0, 99_999_999);
    vals[1] = $urandom;
    vals[2] = $urandom_range(0, 99_999_999);
    vals[3] = '0;
    bus.i_start = 1'b1;
    bus.i_bin   = vals[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("b2b_accept_busy", 64'(bus.o_busy), 64'd1);
      check("b2b_done_low",    64'(bus.o_done), 64'd0);
      bus.i_bin = vals[i+1];
      if (i == 2) bus.i_start = 1'b0;
      wait_done(1'b0, lat, bcnt);
      check("b2b_lat",  64'(lat), 64'd33);
      check("b2b_data", bus.o_data, model(vals[i]));
      check("b2b_ovf",  64'(bus.o_ovf), 64'(vals[i] > MAX_DEC));
    end
    @(posedge clk); #1;
    check("b2b_end_done", 64'(bus.o_done), 64'd0);
    check("b2b_end_busy", 64'(bus.o_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the 8-digit seven-segment driver. It converts an unsigned binary value into 8 BCD nibbles, presented on a 64-bit bus for the driver's character mode (disp_mode = 0). This lets the board show register and ALU results in decimal instead of hex.

Parameters:
IN_W, 32, width of the binary input; fixed iteration count per conversion = IN_W.
MAX_DEC, 99_999_999, largest value representable in 8 decimal digits; larger inputs flag overflow.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
i_start  input  1  conversion request; sampled only in IDLE
i_bin  input  IN_W  unsigned binary value; sampled on the accepting edge only
o_busy  output  1  high while a conversion is in progress (state != IDLE)
o_done  output  1  one-cycle pulse: o_data/o_ovf just updated
o_ovf  output  1  last conversion input exceeded MAX_DEC
o_data  output  64  [31:0] packed BCD, digit 0 in [3:0]; [63:32] always 0

Behaviour:
- Reset (rst = 1 at a clk edge): state = IDLE, o_data = 0, o_busy = 0, o_done = 0, o_ovf = 0, internal shift/BCD/counter registers cleared. Reset wins over every other event.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT when i_start = 1 at edge E0:
  - bin_sr <= i_bin, bcd_sr <= 0, cnt <= 0.
  - ovf_pend <= (i_bin > MAX_DEC).
- SHIFT, one step per edge:
  - Every nibble of bcd_sr that is >= 5 gets +3 (combinational).
  - Then {bcd_sr, bin_sr} shifts left by 1; bcd_sr is 32 bits and its MSB shift-out is discarded.
  - cnt increments; after IN_W steps (cnt == IN_W-1 on that edge) go to DONE.
- DONE, one cycle:
  - On entry edge (E0+IN_W+1 = E0+33 by default): o_data[31:0] <= ovf_pend ? 32'hEEEE_EEEE : bcd_sr; o_ovf <= ovf_pend; o_done = 1.
  - Next edge returns to IDLE and clears o_done.
- Latency: i_start sampled at E0 gives o_done high during the cycle after edge E0+33. A new start is accepted no earlier than edge E0+34.
- o_busy = 1 from E0+1 through the end of the DONE cycle.
- i_start while o_busy = 1 is ignored: no queueing, no effect on the current conversion. i_bin changes during a conversion are ignored.
- Latency is constant whether or not overflow occurs; the shifter still runs.
- o_data and o_ovf hold their last value between conversions. They change only in DONE or on reset.
- Reset mid-SHIFT aborts the conversion: no o_done, o_data = 0.
- Inputs <= MAX_DEC never overflow the 8-digit bcd_sr. Overflowing inputs may corrupt bcd_sr; that value is discarded.

Decomposition:
- Shared package bcd_pkg:
  - State enum (IDLE, SHIFT, DONE).
  - BCD_DIGITS = 8, NIB_W = 4, ADJ_THRESH = 4'd5, ADJ_ADD = 4'd3.
  - OVF_NIBBLE = 4'hE, MAX_DEC.
- One sub-module, bcd_digit_adj: combinational 4-bit "add 3 if >= 5". Instantiated BCD_DIGITS times by a generate loop.

Test Plan:
- Reset, then i_bin = 0 with a start pulse -> o_done at E0+33; o_data = 64'h0; o_ovf = 0; o_busy high exactly 33 cycles.
- i_bin = 12_345_678 -> o_data = 64'h0000_0000_1234_5678; o_ovf = 0. Check o_done is a single-cycle pulse and o_data holds afterwards.
- Boundaries:
  - i_bin = 99_999_999 -> 32'h9999_9999, o_ovf = 0.
  - i_bin = 100_000_000 -> 32'hEEEE_EEEE, o_ovf = 1.
  - i_bin = 32'hFFFF_FFFF -> 32'hEEEE_EEEE, o_ovf = 1.
- Start 1234 at E0, then a start with 5678 at E0+5, plus i_bin toggling while busy -> only the first completes, o_data = 32'h0000_1234. The next start, at E0+34, yields 32'h0000_5678.
- Conversion of 42 with rst asserted at E0+10 -> o_data = 0, o_busy = 0, no o_done. A fresh start of 42 afterwards -> 32'h0000_0042 after 33 edges.
- Back-to-back: start asserted continuously -> conversions accepted every 34 cycles, each o_done exactly one cycle.
